// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the instruction fetcher and the load/store
// buffer onto a single byte-wide memory/IO bus. Each request is split into
// byte transfers, read bytes are assembled little-endian, IO writes are
// throttled by io_buffer_full, and rdy / rollback are honoured.
module mem_bus_arbiter #(
    parameter int IF_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_en,
    input  logic [31:0]           if_pc,
    output logic                  if_done,
    output logic [IF_BYTES*8-1:0] if_data,
    input  logic                  lsb_en,
    input  logic                  lsb_wr,
    input  logic [31:0]           lsb_addr,
    input  logic [1:0]            lsb_len,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata
);

    // Counters must be able to hold the value IF_BYTES itself ("all issued").
    localparam int CW = $clog2(IF_BYTES) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IF_RD = 2'd1;
    localparam logic [1:0] S_LS_RD = 2'd2;
    localparam logic [1:0] S_LS_WR = 2'd3;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_LSB = 1'b1;

    logic [1:0]            state_reg;
    logic                  last_grant_reg;
    logic [31:0]           base_reg;
    logic [31:0]           wdata_reg;
    logic [CW-1:0]         len_reg;
    logic [CW-1:0]         ai_reg;
    logic [CW-1:0]         ci_reg;
    logic                  iv_reg;
    logic [IF_BYTES*8-1:0] buf_reg;
    logic [IF_BYTES*8-1:0] buf_next;
    logic [7:0]            dout_reg;
    logic                  if_done_reg;
    logic                  lsb_done_reg;
    logic [IF_BYTES*8-1:0] if_data_reg;
    logic [31:0]           lsb_rdata_reg;

    logic          grant_any;
    logic          grant_lsb;
    logic [CW-1:0] lsb_len_n;
    logic          rd_state;
    logic          rd_issue;
    logic          cap;
    logic          last_cap;
    logic [31:0]   cur_addr;
    logic          io_block;
    logic          wr_go;
    logic [7:0]    wr_byte;

    // Under contention the LSB wins unless it was the last one served.
    assign grant_any = (if_en || lsb_en) && !rollback;
    assign grant_lsb = lsb_en && (!if_en || (last_grant_reg != GRANT_LSB));
    assign lsb_len_n = (lsb_len == 2'b00) ? CW'(1) :
                       (lsb_len == 2'b01) ? CW'(2) : CW'(4);

    assign rd_state = (state_reg == S_IF_RD) || (state_reg == S_LS_RD);
    assign rd_issue = rd_state && (ai_reg < len_reg);
    assign cap      = rd_state && iv_reg && rdy && !rollback;
    assign last_cap = cap && (ci_reg == len_reg - CW'(1));
    assign cur_addr = base_reg + 32'(ai_reg);
    assign io_block = (cur_addr[17:16] == 2'b11) && io_buffer_full;
    assign wr_go    = (state_reg == S_LS_WR) && rdy && !io_block;
    assign wr_byte  = wdata_reg[{ai_reg[1:0], 3'b000} +: 8];

    // Arriving read byte lands in the slot selected by the capture index.
    generate
        for (genvar gi = 0; gi < IF_BYTES; gi++) begin : g_buf
            assign buf_next[gi*8 +: 8] = (cap && (ci_reg == CW'(gi))) ? mem_din
                                                                       : buf_reg[gi*8 +: 8];
        end
    endgenerate

    // Bus address: only while a read byte is still to be issued, or a write
    // byte is pending and not held back by the IO throttle.
    always_comb begin
        mem_a = 32'd0;
        if (rd_issue || ((state_reg == S_LS_WR) && !io_block)) begin
            mem_a = cur_addr;
        end
    end

    assign mem_wr    = wr_go;
    assign mem_dout  = wr_go ? wr_byte : dout_reg;
    // Done pulses held in their registers while stalled, released on rdy.
    assign if_done   = if_done_reg && rdy;
    assign lsb_done  = lsb_done_reg && rdy;
    assign if_data   = if_data_reg;
    assign lsb_rdata = lsb_rdata_reg;

    // Sequencer: grant, byte issue/capture, write stepping and completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            last_grant_reg <= GRANT_IF;
            base_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            len_reg        <= '0;
            ai_reg         <= '0;
            ci_reg         <= '0;
            iv_reg         <= 1'b0;
            buf_reg        <= '0;
            dout_reg       <= 8'd0;
            if_done_reg    <= 1'b0;
            lsb_done_reg   <= 1'b0;
            if_data_reg    <= '0;
            lsb_rdata_reg  <= 32'd0;
        end else if (!rdy) begin
            // The in-flight byte is dropped; restart issue at the first
            // uncaptured byte so nothing is lost or duplicated.
            iv_reg <= 1'b0;
            if (rd_state) begin
                ai_reg <= ci_reg;
            end
        end else begin
            if_done_reg  <= 1'b0;
            lsb_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (grant_any) begin
                        last_grant_reg <= grant_lsb ? GRANT_LSB : GRANT_IF;
                        base_reg       <= grant_lsb ? lsb_addr : if_pc;
                        len_reg        <= grant_lsb ? lsb_len_n : CW'(IF_BYTES);
                        wdata_reg      <= lsb_wdata;
                        state_reg      <= !grant_lsb ? S_IF_RD :
                                          (lsb_wr ? S_LS_WR : S_LS_RD);
                        ai_reg         <= '0;
                        ci_reg         <= '0;
                        iv_reg         <= 1'b0;
                        buf_reg        <= '0;
                    end
                end
                S_IF_RD, S_LS_RD: begin
                    if (rollback) begin
                        state_reg <= S_IDLE;
                        iv_reg    <= 1'b0;
                    end else begin
                        iv_reg <= rd_issue;
                        if (rd_issue) begin
                            ai_reg <= ai_reg + CW'(1);
                        end
                        if (cap) begin
                            buf_reg <= buf_next;
                            ci_reg  <= ci_reg + CW'(1);
                        end
                        if (last_cap) begin
                            state_reg <= S_IDLE;
                            if (state_reg == S_IF_RD) begin
                                if_data_reg <= buf_next;
                                if_done_reg <= 1'b1;
                            end else begin
                                lsb_rdata_reg <= buf_next[31:0];
                                lsb_done_reg  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // Committed stores run to completion regardless of rollback.
                    if (wr_go) begin
                        dout_reg <= wr_byte;
                        ai_reg   <= ai_reg + CW'(1);
                        if (ai_reg == len_reg - CW'(1)) begin
                            state_reg    <= S_IDLE;
                            lsb_done_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected done pulses,
// bus writes and timed output probes; one monitor pops and compares them.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_en;
    logic [31:0] if_pc = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_en;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [1:0]  lsb_len = 2'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    logic if_req = 1'b0;
    logic lsb_req = 1'b0;
    // Requesters drop their enable in the cycle their done pulse appears.
    assign if_en  = if_req && !if_done;
    assign lsb_en = lsb_req && !lsb_done;

    mem_bus_arbiter #(.IF_BYTES(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: read data appears the cycle after its address.
    logic [7:0] mem [logic [31:0]];
    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction
    always @(posedge clk) mem_din <= rd_byte(mem_a);

    typedef struct { bit is_lsb; bit chk; logic [31:0] data; int cyc; } done_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef struct { int cyc; int sel; logic [31:0] val; string name; } probe_t;

    done_t  exp_done[$];
    wr_t    exp_wr[$];
    probe_t probes[$];

    int errors = 0;
    int checks = 0;
    bit stim_timeout = 1'b0;
    bit finish_req = 1'b0;
    bit to_seen = 1'b0;

    function automatic logic [31:0] probe_val(input int sel);
        case (sel)
            0: return mem_a;
            1: return {31'd0, mem_wr};
            2: return {24'd0, mem_dout};
            3: return if_data;
            4: return lsb_rdata;
            default: return {30'd0, if_done, lsb_done};
        endcase
    endfunction

    // Monitor: the only place comparisons are made and counted.
    done_t       dd;
    wr_t         ww;
    probe_t      pr;
    logic [31:0] act;
    bit          ok;
    always @(negedge clk) begin
        if (rst) begin
            while (probes.size() > 0 && probes[0].cyc <= cyc) begin
                pr = probes.pop_front();
                act = probe_val(pr.sel);
                checks++;
                if (pr.cyc != cyc || act !== pr.val) begin
                    errors++;
                    $display("FAIL probe %s cyc=%0d (want cyc %0d) actual=%h expected=%h",
                             pr.name, cyc, pr.cyc, act, pr.val);
                end
            end
            if (if_done || lsb_done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d if_done=%0b lsb_done=%0b expected none",
                             cyc, if_done, lsb_done);
                end else begin
                    dd = exp_done.pop_front();
                    act = dd.is_lsb ? lsb_rdata : if_data;
                    ok = (if_done != lsb_done) && (lsb_done == dd.is_lsb) && (cyc == dd.cyc) &&
                         (!dd.chk || act === dd.data);
                    if (!ok) begin
                        errors++;
                        $display("FAIL done cyc=%0d if=%0b lsb=%0b data=%h expected lsb=%0b cyc=%0d data=%h",
                                 cyc, if_done, lsb_done, act, dd.is_lsb, dd.cyc, dd.data);
                    end else begin
                        $display("done %s cyc=%0d data=%h", dd.is_lsb ? "lsb" : "if", cyc, act);
                    end
                end
            end
            if (mem_wr) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected cyc=%0d addr=%h data=%h expected none",
                             cyc, mem_a, mem_dout);
                end else begin
                    ww = exp_wr.pop_front();
                    if (mem_a !== ww.addr || mem_dout !== ww.data || cyc != ww.cyc) begin
                        errors++;
                        $display("FAIL write cyc=%0d addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                                 cyc, mem_a, mem_dout, ww.cyc, ww.addr, ww.data);
                    end else begin
                        $display("write cyc=%0d addr=%h data=%h", cyc, mem_a, mem_dout);
                    end
                end
            end
        end
        if (stim_timeout && !to_seen) begin
            to_seen = 1'b1;
            checks++;
            errors++;
            $display("FAIL wait_timeout cyc=%0d done pulse never arrived", cyc);
        end
        if (finish_req || cyc > 20000) begin
            checks++;
            if (cyc > 20000 || exp_done.size() != 0 || exp_wr.size() != 0 || probes.size() != 0) begin
                errors++;
                $display("FAIL drain cyc=%0d pending done=%0d writes=%0d probes=%0d expected 0",
                         cyc, exp_done.size(), exp_wr.size(), probes.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int c, input int sel, input logic [31:0] v, input string n);
        probe_t p;
        p.cyc = c; p.sel = sel; p.val = v; p.name = n;
        probes.push_back(p);
    endtask

    task automatic exp_d(input bit is_lsb, input bit chk, input logic [31:0] d, input int c);
        done_t e;
        e.is_lsb = is_lsb; e.chk = chk; e.data = d; e.cyc = c;
        exp_done.push_back(e);
    endtask

    task automatic exp_w(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_t e;
        e.addr = a; e.data = d; e.cyc = c;
        exp_wr.push_back(e);
    endtask

    // Bounded wait for a done pulse, then leave at the start of the next cycle.
    task automatic wait_done(input bit lsb);
        int n = 0;
        forever begin
            @(negedge clk);
            if (lsb ? lsb_done : if_done) break;
            n++;
            if (n > 200) begin
                stim_timeout = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic run_if(input logic [31:0] pc);
        if_pc  = pc;
        if_req = 1'b1;
        wait_done(1'b0);
        if_req = 1'b0;
    endtask

    task automatic run_lsb(input logic wr, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] wd);
        lsb_wr    = wr;
        lsb_addr  = a;
        lsb_len   = len;
        lsb_wdata = wd;
        lsb_req   = 1'b1;
        wait_done(1'b1);
        lsb_req = 1'b0;
    endtask

    int t;
    initial begin
        mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
        mem[32'h200] = 8'h11; mem[32'h201] = 8'h22; mem[32'h202] = 8'h33; mem[32'h203] = 8'h44;
        mem[32'h300] = 8'hAA; mem[32'h301] = 8'hBB; mem[32'h302] = 8'hCC; mem[32'h303] = 8'hDD;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        t = cyc;
        probe(t, 0, 32'h0, "rst_mem_a");
        probe(t, 1, 32'h0, "rst_mem_wr");
        probe(t, 2, 32'h0, "rst_mem_dout");
        probe(t, 3, 32'h0, "rst_if_data");
        probe(t, 4, 32'h0, "rst_lsb_rdata");
        probe(t, 5, 32'h0, "rst_done");
        tick();

        // Contention twice: LSB first each round, IF granted in the LSB done cycle.
        for (int r = 0; r < 2; r++) begin
            t = cyc;
            exp_d(1'b1, 1'b1, 32'hDDCCBBAA, t + 6);
            exp_d(1'b0, 1'b1, 32'h00000513, t + 12);
            probe(t + 7, 0, 32'h100, "contend_if_addr0");
            fork
                run_lsb(1'b0, 32'h300, 2'b10, 32'h0);
                run_if(32'h100);
            join
        end

        // Plain fetch: address sequence, then mem_a back to 0.
        t = cyc;
        for (int k = 0; k < 4; k++) probe(t + 1 + k, 0, 32'h100 + k, "if_addr");
        probe(t + 5, 0, 32'h0, "if_addr_done");
        exp_d(1'b0, 1'b1, 32'h00000513, t + 6);
        run_if(32'h100);

        // Loads of each length, zero-filled; length 11 behaves as word.
        t = cyc; exp_d(1'b1, 1'b1, 32'h0000CCBB, t + 4); run_lsb(1'b0, 32'h301, 2'b01, 32'h0);
        t = cyc; exp_d(1'b1, 1'b1, 32'h000000DD, t + 3); run_lsb(1'b0, 32'h303, 2'b00, 32'h0);
        t = cyc; exp_d(1'b1, 1'b1, 32'hDDCCBBAA, t + 6); run_lsb(1'b0, 32'h300, 2'b11, 32'h0);

        // Store word, then mem_dout holds the last byte in IDLE.
        t = cyc;
        exp_w(32'h1000, 8'hEF, t + 1); exp_w(32'h1001, 8'hBE, t + 2);
        exp_w(32'h1002, 8'hAD, t + 3); exp_w(32'h1003, 8'hDE, t + 4);
        exp_d(1'b1, 1'b0, 32'h0, t + 5);
        probe(t + 5, 2, 32'hDE, "dout_hold");
        probe(t + 5, 0, 32'h0, "wr_idle_addr");
        run_lsb(1'b1, 32'h1000, 2'b10, 32'hDEADBEEF);

        // Store byte at the top of the address space.
        t = cyc;
        exp_w(32'hFFFFFFFF, 8'h5C, t + 1);
        exp_d(1'b1, 1'b0, 32'h0, t + 2);
        run_lsb(1'b1, 32'hFFFFFFFF, 2'b00, 32'h0000005C);

        // IO store held back by a full UART buffer for three cycles.
        t = cyc;
        exp_w(32'h30000, 8'h41, t + 4);
        exp_d(1'b1, 1'b0, 32'h0, t + 5);
        probe(t + 2, 0, 32'h0, "io_block_addr");
        fork
            run_lsb(1'b1, 32'h30000, 2'b00, 32'h00000041);
            begin
                io_buffer_full = 1'b1;
                repeat (4) tick();
                io_buffer_full = 1'b0;
            end
        join

        // Rollback during a fetch: aborted, no done pulse.
        t = cyc;
        if_pc  = 32'h400;
        if_req = 1'b1;
        probe(t + 3, 0, 32'h402, "rb_if_addr");
        probe(t + 4, 0, 32'h0, "rb_if_idle");
        repeat (3) tick();
        rollback = 1'b1;
        if_req   = 1'b0;
        tick();
        rollback = 1'b0;
        repeat (8) tick();

        // Rollback during a store: all bytes still written.
        t = cyc;
        exp_w(32'h2000, 8'h0D, t + 1); exp_w(32'h2001, 8'hF0, t + 2);
        exp_w(32'h2002, 8'hFE, t + 3); exp_w(32'h2003, 8'hCA, t + 4);
        exp_d(1'b1, 1'b0, 32'h0, t + 5);
        fork
            run_lsb(1'b1, 32'h2000, 2'b10, 32'hCAFEF00D);
            begin
                repeat (2) tick();
                rollback = 1'b1;
                tick();
                rollback = 1'b0;
            end
        join

        // Two-cycle stall in the middle of a fetch.
        t = cyc;
        probe(t + 3, 1, 32'h0, "stall_wr0");
        probe(t + 4, 1, 32'h0, "stall_wr1");
        exp_d(1'b0, 1'b1, 32'h44332211, t + 9);
        fork
            run_if(32'h200);
            begin
                repeat (3) tick();
                rdy = 1'b0;
                repeat (2) tick();
                rdy = 1'b1;
            end
        join

        repeat (5) tick();
        finish_req = 1'b1;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Byte-serial memory-bus sequencer and arbiter for the RV32I core. It sits between the instruction fetcher and the load/store buffer on one side and the 8-bit external memory/IO bus on the other. It grants the single bus to one requester at a time with alternating priority under contention. It splits each request into byte transfers, assembles read data little-endian, throttles IO writes on `io_buffer_full`, and honours `rdy` and `rollback`.

## Interface
- `IF_BYTES`, 4: bytes per fetch request; power of two, 4..64.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  pause: when 0, no state advances.
- `rollback`  in  1  branch mispredict flush.
- `mem_din`  in  8  read data byte, valid the cycle after its address.
- `mem_dout`  out  8  write data byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write this cycle.
- `io_buffer_full`  in  1  UART tx buffer full.
- `if_en`  in  1  fetch request; held until `if_done`.
- `if_pc`  in  32  fetch start address.
- `if_done`  out  1  one-cycle pulse, `if_data` valid.
- `if_data`  out  IF_BYTES*8  fetched bytes, byte 0 in bits [7:0].
- `lsb_en`  in  1  load/store request; held until `lsb_done`.
- `lsb_wr`  in  1  1 = store.
- `lsb_addr`  in  32  start address.
- `lsb_len`  in  2  00 byte, 01 half, 10 word; 11 illegal (treated as word).
- `lsb_wdata`  in  32  store data, byte 0 in [7:0].
- `lsb_done`  out  1  one-cycle pulse; load data valid.
- `lsb_rdata`  out  32  raw load bytes, zero-filled above length (sign extension is the LSB's job).

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR. Requests are sampled only in IDLE, and only with `rdy`=1 and `rollback`=0.
- Arbitration in IDLE uses register `last_grant`. Only one request: grant it. Both: grant LSB unless `last_grant`=LSB, else IF. Update `last_grant` on each grant.
- On grant, latch address, length N (IF: IF_BYTES; LSB: 1/2/4), write data and direction. Clear byte counters.
- Reads:
  - Issue index `ai` drives `mem_a = base + ai`.
  - Flag `iv` records that last cycle issued a read with `rdy`=1. When `iv`=1, the arriving `mem_din` is stored at capture index `ci`.
  - After byte N-1 is captured, pulse done next cycle with data and return to IDLE. `mem_a`=0 once all issued.
- Writes:
  - Byte k drives `mem_a = base + k`, `mem_dout = wdata[8k+7:8k]`, `mem_wr`=1.
  - After byte N-1, pulse `lsb_done` next cycle and return to IDLE.
- IO throttle: a write with address[17:16]=2'b11 emits a byte only in cycles with `io_buffer_full`=0. Otherwise `mem_wr`=0, `mem_a`=0, and the counter holds.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- `rollback`=1 in IF_RD or LS_RD: abort. Next state IDLE, no done pulse, partial data discarded, `mem_wr`=0. In LS_WR, rollback is ignored: committed stores always complete and pulse `lsb_done`.
- `rdy`=0: all state, counters and outputs hold, except:
  - `mem_wr` is forced to 0.
  - done pulses are suppressed and deferred to the next `rdy`=1 cycle.
  - `iv` is cleared, so the byte issued under stall is re-issued after `rdy` returns.
- In IDLE: `mem_a`=0, `mem_wr`=0. `mem_dout` holds its last value.
- Reset values:
  - state IDLE, `last_grant`=IF (first contention goes to LSB).
  - `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
  - `if_done`=0, `lsb_done`=0, `if_data`=0, `lsb_rdata`=0, all counters 0.

## Timing
Request seen in IDLE at cycle t.
- Read of N bytes:
  - address k driven in cycle t+1+k; byte k captured at the end of cycle t+2+k.
  - done pulse in cycle t+N+2.
  - IF_BYTES=4 gives 6 cycles.
- Write of N bytes: bytes in cycles t+1..t+N; done in t+N+1.
- Next request may be granted in the done cycle, giving back-to-back transfers with no gap.
- Each `rdy`=0 stall of s cycles during a read adds s+1 cycles; during a write, s cycles.
- Each cycle of `io_buffer_full`=1 at a pending IO byte adds 1 cycle.
- Done pulses last exactly one cycle. Data outputs hold until the next done.

## Test plan
- IF read, `if_pc`=0x100, memory bytes 13 05 00 00:
  - `mem_a` = 0x100..0x103 in t+1..t+4.
  - `if_done` at t+6 with `if_data`=0x00000513.
- Reset, then `if_en` and `lsb_en` (load word) both held from the same cycle:
  - LSB granted first, then IF.
  - Repeat with both high again: order is LSB, then IF, alternating; neither starves.
- Store word 0xDEADBEEF to 0x1000:
  - `mem_wr`=1 in t+1..t+4 with addresses 0x1000..0x1003 and bytes EF BE AD DE.
  - `lsb_done` at t+5. Store byte to 0xFFFFFFFF uses `mem_a`=0xFFFFFFFF.
- Store byte 0x41 to 0x30000 with `io_buffer_full`=1 for cycles t+1..t+3:
  - `mem_wr`=0 through t+3; write in t+4.
  - `lsb_done` at t+5.
- Rollback:
  - During IF read at t+3: no `if_done`, IDLE at t+4, `mem_a`=0.
  - During a word store at t+2: all 4 bytes still written, `lsb_done` at t+5.
- `rdy`=0 in t+3..t+4 during IF read of 0x200:
  - `mem_wr` stays 0.
  - `if_done` at t+9 with correct data; no duplicated or missing byte.
